// File: rtl/fp_pkg.sv
// Shared FP32 field constants and argmax types for the classifier readout path.
package fp_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  localparam int ARGMAX_N     = 10;
  localparam int ARGMAX_IDX_W = 4;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[EXP_MSB:EXP_LSB] == EXP_ALL1) && (x[MANT_W-1:0] != '0);
  endfunction
endpackage

// File: rtl/fp_argmax_if.sv
// Vector-in / decision-out handshake bundle for fp_argmax.
interface fp_argmax_if import fp_pkg::*; #(
  parameter int N     = ARGMAX_N,
  parameter int IDX_W = ARGMAX_IDX_W
) ();
  logic [31:0]      d_in [N];
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] class_idx;
  logic [31:0]      max_val;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  d_in, in_valid, out_ready,
    output in_ready, class_idx, max_val, out_valid
  );

  modport master (
    output d_in, in_valid, out_ready,
    input  in_ready, class_idx, max_val, out_valid
  );
endinterface

// File: rtl/fp_gt.sv
// Combinational IEEE-754 FP32 strict greater-than; NaN ranks below -inf, +0 == -0.
module fp_gt import fp_pkg::*; (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        gt_o
);
  logic a_nan, b_nan, both_zero;

  assign a_nan     = is_nan(a_i);
  assign b_nan     = is_nan(b_i);
  assign both_zero = (a_i[EXP_MSB:0] == '0) && (b_i[EXP_MSB:0] == '0);

  always_comb begin
    gt_o = 1'b0;
    if (a_nan) begin
      gt_o = 1'b0;
    end else if (b_nan) begin
      gt_o = 1'b1;
    end else if (both_zero) begin
      gt_o = 1'b0;
    end else if (a_i[SIGN_BIT] != b_i[SIGN_BIT]) begin
      gt_o = ~a_i[SIGN_BIT];
    end else if (!a_i[SIGN_BIT]) begin
      gt_o = a_i[EXP_MSB:0] > b_i[EXP_MSB:0];
    end else begin
      gt_o = a_i[EXP_MSB:0] < b_i[EXP_MSB:0];
    end
  end
endmodule

// File: rtl/fp_argmax.sv
// Sequential argmax over N FP32 class scores, one element per cycle.
module fp_argmax import fp_pkg::*; #(
  parameter int N     = ARGMAX_N,
  parameter int IDX_W = ARGMAX_IDX_W
) (
  input  logic clk,
  input  logic rst,
  fp_argmax_if.slave bus
);
  argmax_state_t    state_q, state_d;
  logic [31:0]      vec_q [N];
  logic [31:0]      vec_d [N];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [31:0]      best_val_q, best_val_d;
  logic             commit_q, commit_d;
  logic [IDX_W-1:0] cidx_q, cidx_d;
  logic [31:0]      mval_q, mval_d;
  logic             cand_gt;

  fp_gt u_gt (
    .a_i  (vec_q[idx_q]),
    .b_i  (best_val_q),
    .gt_o (cand_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < N; i++) vec_q[i] <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      commit_q   <= 1'b0;
      cidx_q     <= '0;
      mval_q     <= '0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < N; i++) vec_q[i] <= vec_d[i];
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      commit_q   <= commit_d;
      cidx_q     <= cidx_d;
      mval_q     <= mval_d;
    end
  end

  // After the last element is compared, one commit cycle copies the winner into
  // the output registers so the outputs stay frozen while the next scan runs.
  always_comb begin
    state_d    = state_q;
    for (int i = 0; i < N; i++) vec_d[i] = vec_q[i];
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    commit_d   = commit_q;
    cidx_d     = cidx_q;
    mval_d     = mval_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          for (int i = 0; i < N; i++) vec_d[i] = bus.d_in[i];
          best_val_d = bus.d_in[0];
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
          commit_d   = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (commit_q) begin
          cidx_d   = best_idx_q;
          mval_d   = best_val_q;
          commit_d = 1'b0;
          state_d  = DONE;
        end else begin
          if (cand_gt) begin
            best_val_d = vec_q[idx_q];
            best_idx_d = idx_q;
          end
          if (idx_q == IDX_W'(N - 1)) commit_d = 1'b1;
          else                        idx_d    = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.class_idx = cidx_q;
  assign bus.max_val   = mval_q;
endmodule

// File: tb/tb_fp_argmax.sv
// Directed-vector bench for fp_argmax: table of vectors plus backpressure and reset-abort sequences.
module tb_fp_argmax;
  localparam int N     = 10;
  localparam int IDX_W = 4;

  typedef struct {
    logic [N-1:0][31:0] d;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        val;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  fp_argmax_if #(.N(N), .IDX_W(IDX_W)) bus ();

  fp_argmax #(.N(N), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive_d(input logic [N-1:0][31:0] d);
    for (int i = 0; i < N; i++) bus.d_in[i] = d[i];
  endtask

  // Accept a vector, scribble d_in afterwards, return cycles until out_valid.
  task automatic send(input logic [N-1:0][31:0] d, output int lat);
    logic [N-1:0][31:0] junk;
    for (int i = 0; i < N; i++) junk[i] = 32'h7F000000;
    @(negedge clk);
    drive_d(d);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drive_d(junk);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({name, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
    check({name, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    logic [N-1:0][31:0] asc, alt;
    int lat;
    bit seen;

    asc[0] = 32'h3F800000; asc[1] = 32'h40000000; asc[2] = 32'h40400000;
    asc[3] = 32'h40800000; asc[4] = 32'h40A00000; asc[5] = 32'h40C00000;
    asc[6] = 32'h40E00000; asc[7] = 32'h41000000; asc[8] = 32'h41100000;
    asc[9] = 32'h41200000;
    vecs[0].d = asc; vecs[0].idx = 4'd9; vecs[0].val = 32'h41200000;

    for (int i = 0; i < N; i++) vecs[1].d[i] = 32'hBF800000;
    vecs[1].d[4] = 32'hBF000000; vecs[1].idx = 4'd4; vecs[1].val = 32'hBF000000;

    for (int i = 0; i < N; i++) vecs[2].d[i] = 32'h3F800000;
    vecs[2].d[2] = 32'h40000000; vecs[2].d[7] = 32'h40000000;
    vecs[2].idx = 4'd2; vecs[2].val = 32'h40000000;

    for (int i = 0; i < N; i++) vecs[3].d[i] = 32'hBF800000;
    vecs[3].d[0] = 32'h80000000; vecs[3].d[1] = 32'h00000000;
    vecs[3].idx = 4'd0; vecs[3].val = 32'h80000000;

    for (int i = 0; i < N; i++) vecs[4].d[i] = 32'h3F800000;
    vecs[4].d[0] = 32'h7FC00000; vecs[4].d[5] = 32'h7F800000;
    vecs[4].idx = 4'd5; vecs[4].val = 32'h7F800000;

    for (int i = 0; i < N; i++) vecs[5].d[i] = 32'h7FC00000;
    vecs[5].idx = 4'd0; vecs[5].val = 32'h7FC00000;

    for (int i = 0; i < N; i++) vecs[6].d[i] = 32'hFFC00001;
    vecs[6].d[3] = 32'hFF800000; vecs[6].d[8] = 32'h00000001;
    vecs[6].idx = 4'd8; vecs[6].val = 32'h00000001;

    for (int i = 0; i < N; i++) alt[i] = 32'h42C80000;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_d(alt);

    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_class_idx", 32'(bus.class_idx), 32'd0);
    check("rst_max_val",   bus.max_val,        32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].d, lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd10);
      check($sformatf("v%0d_class_idx", v), 32'(bus.class_idx), 32'(vecs[v].idx));
      check($sformatf("v%0d_max_val", v), bus.max_val, vecs[v].val);
      handshake($sformatf("v%0d", v));
    end

    // Backpressure: result must hold and new in_valid must be ignored.
    send(vecs[2].d, lat);
    check("bp_latency", 32'(lat), 32'd10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_d(alt);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
      check($sformatf("bp%0d_class_idx", c), 32'(bus.class_idx), 32'd2);
      check($sformatf("bp%0d_max_val", c),   bus.max_val,        32'h40000000);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    handshake("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_spurious_start", 32'(bus.in_ready), 32'd1);

    // Reset during scan cycle 4 aborts without emitting a result.
    @(negedge clk);
    drive_d(vecs[0].d);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_class_idx", 32'(bus.class_idx), 32'd0);
    check("abort_max_val",   bus.max_val,        32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);

    send(vecs[1].d, lat);
    check("post_abort_latency",   32'(lat),           32'd10);
    check("post_abort_class_idx", 32'(bus.class_idx), 32'd4);
    check("post_abort_max_val",   bus.max_val,        32'hBF000000);
    handshake("post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_argmax.md
Name: fp_argmax

Overview:
- Downstream of the 10-lane FP32 output scaling stage.
- Accepts one vector of N scaled IEEE-754 single-precision class scores per transaction and scans it sequentially, one element per cycle.
- Returns the index and value of the maximum score.
- Produces the final class decision that the host/readout logic consumes.

Parameters:
- N, 10, number of class scores per vector (min 2).
- IDX_W, 4, width of class index; must satisfy 2^IDX_W >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  32 x [N-1:0] unpacked array  FP32 scores, same array shape as the scaling stage output.
- in_valid  input  1  d_in valid.
- in_ready  output  1  block can accept a vector.
- class_idx  output  IDX_W  index of maximum score.
- max_val  output  32  FP32 value at class_idx.
- out_valid  output  1  class_idx/max_val valid.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, class_idx=0, max_val=0.
  - Internal vector register, scan counter and best registers cleared.
  - Reset mid-SCAN or mid-DONE aborts the transaction; no result is emitted.
- States:
  - IDLE: in_ready=1. On in_valid, latch all N words of d_in, set best_val=d_in[0], best_idx=0, scan idx=1, and go to SCAN.
  - SCAN: in_ready=0. Each cycle compare vec[idx] against best_val. If gt(vec[idx], best_val), load best_val and best_idx. Increment idx. When idx==N-1 has been processed, go to DONE.
  - DONE: out_valid=1, class_idx=best_idx, max_val=best_val, held stable while out_ready=0. On out_ready=1, go to IDLE.
- Latency and throughput:
  - Vector accepted at edge T.
  - N-1 SCAN cycles.
  - out_valid rises at T+N (T+10 for default N).
  - After the out_ready handshake, in_ready rises the next cycle.
  - Max throughput is one vector per N+2 cycles; there is no accept/output overlap.
- in_valid outside IDLE is ignored. d_in is sampled only on the accept edge, so later changes to d_in have no effect.
- out_ready outside DONE is ignored.
- Comparator gt(a,b), combinational, true when a>b in IEEE ordering:
  - Sign-magnitude compare. For both positive, compare bits[30:0] unsigned. For both negative, the smaller magnitude is greater. Positive beats negative.
  - +0 and -0 are equal, so gt returns false.
  - Denormals and ±inf order naturally via the bit pattern.
  - NaN (exp=0xFF, mant!=0) ranks below -inf: gt(NaN,x)=0, and gt(x,NaN)=1 for non-NaN x.
- Ties: the strict compare keeps the earlier (lowest) index.
- All-NaN vector: class_idx=0, max_val=d_in[0].
- Outputs class_idx/max_val hold their last values in IDLE/SCAN; only out_valid qualifies them.

Decomposition:
- Shared package fp_pkg:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23, EXP_ALL1=8'hFF.
  - Default N and IDX_W.
  - argmax_state_t enum {IDLE, SCAN, DONE}.
- Sub-module fp_gt: purely combinational comparator with inputs a, b and output gt. It is reusable by future max-pooling or softmax max-subtraction stages.

Test Plan:
- Reset then ascending vector {1.0..10.0} (0x3F800000..0x41200000) -> out_valid at accept+10, class_idx=9, max_val=0x41200000.
- Vector with all -1.0 (0xBF800000) except d[4]=-0.5 (0xBF000000) -> class_idx=4, max_val=0xBF000000.
- Ties, d[2]=d[7]=2.0 (0x40000000) and others 1.0 -> class_idx=2. Separately, d[0]=-0 (0x80000000), d[1]=+0, rest negative -> class_idx=0.
- d[0]=NaN 0x7FC00000, d[5]=+inf 0x7F800000, rest 1.0 -> class_idx=5. All-NaN vector -> class_idx=0, max_val=0x7FC00000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0. Toggle in_valid with new data meanwhile -> ignored. Release -> in_ready=1 one cycle after the handshake.
- Assert rst for 1 cycle at SCAN cycle 4 -> outputs immediately zero, in_ready=1, no out_valid. Next vector gives the correct result with full latency.
